alu_arbiter: RTL
================

# alu_arbiter

Shares the single combinational `alu` between two requesters (e.g. integer execute and address-generation) using valid/ready handshakes and round-robin arbitration. It latches the winner's operands, runs one ALU evaluation, registers the result, and returns it on a single response channel tagged with the requester ID. It instantiates `alu` internally; no ALU ports leave the block.

## Interface
- `XLEN`, default 32: operand and result width.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  2: bit i set means requester i presents an operation.
- `req_ready`  out  2: bit i set means requester i's operation is accepted this cycle; at most one bit set (one-hot or zero).
- `req_funct7`  in  14: `[7i+6:7i]` is the funct7 of requester i.
- `req_funct3`  in  6: `[3i+2:3i]` is the funct3 of requester i.
- `req_src1`  in  2*XLEN: `[XLEN*i +: XLEN]` is operand 1 of requester i.
- `req_src2`  in  2*XLEN: same packing, operand 2.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer takes the result.
- `rsp_id`  out  1: requester index that owns `rsp_result`.
- `rsp_result`  out  XLEN: registered ALU result.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Uses a 3-state FSM: IDLE → EXEC → RESP → IDLE.
- **IDLE:** if any `req_valid` is set, the block grants one requester.
  - Both valid: grant = `prio`.
  - One valid: grant that one.
  - `req_ready[grant]` is driven combinationally in the same cycle. That handshake latches funct7, funct3, src1 and src2 into operand registers and the grant into `id_q`, then moves to EXEC.
  - No valid: stay in IDLE; `req_ready` = 0.
- **EXEC:** the ALU is driven from the operand registers. `alu.result` is captured into `rsp_result`, `rsp_id` ← `id_q`, then moves to RESP.
- **RESP:** `rsp_valid` = 1. `rsp_result` and `rsp_id` are held stable until `rsp_ready`.
  - On `rsp_ready`: go to IDLE and set `prio` ← `~id_q`.
  - `req_ready` = 0 throughout RESP.
- ALU opcode semantics pass through unchanged: funct7 = 0000000 / funct3 = 000 is ADD, funct7 = 0100000 / funct3 = 000 is SUB. Results wrap modulo 2^XLEN. The arbiter does not check opcode legality.
- Requester i may drop `req_valid` before being granted; no side effect.
- `req_valid` held across a grant is treated as a new request on the next IDLE.

## Timing
- Reset values: FSM = IDLE, `prio` = 0, operand registers = 0, `id_q` = 0, `rsp_result` = 0, `rsp_id` = 0, `rsp_valid` = 0, `req_ready` = 0, `busy` = 0.
- Latency: handshake at cycle T, `rsp_valid` rises at T+2.
- Peak throughput: 1 op per 3 cycles with `rsp_ready` tied high.
- Back-pressure: RESP may last any number of cycles. No new request is accepted until the cycle after the response handshake.
- Simultaneous requests: a requester that loses arbitration wins the next IDLE in which it is still valid, so there is no starvation.
- Reset in any state aborts the in-flight operation, produces no response, and restores all reset values the next cycle.
- `rsp_ready` while `rsp_valid` = 0 is ignored.

## Structure
- Package `alu_arb_pkg` holds:
  - state enum `{ST_IDLE, ST_EXEC, ST_RESP}`;
  - `F7_BASE` = 7'b0000000, `F7_ALT` = 7'b0100000;
  - `F3_ADD` = 3'b000.
- Sub-module: the existing `alu`, as a single instance with ports `funct7`, `funct3`, `source1`, `source2`, `result`.
- Grant logic is inline (two requesters).

## Test plan
- After reset with no requests: `req_ready` = 00, `rsp_valid` = 0, `busy` = 0, `rsp_result` = 0.
- req0 only, ADD, 2 + 1, `rsp_ready` high → `req_ready` = 01 at T, `rsp_valid` at T+2 with `rsp_id` = 0, `rsp_result` = 3.
- req1 only, SUB, 2 − 1 → `rsp_id` = 1, `rsp_result` = 1; SUB of 0 − 1 → 32'hFFFF_FFFF.
- Both valid continuously, `rsp_ready` high → grants alternate 0, 1, 0, 1 (prio starts 0); responses every 3 cycles with matching `rsp_id`.
- Hold `rsp_ready` low 5 cycles in RESP → `rsp_valid` and `rsp_result` stable, `req_ready` = 00; release → return to IDLE next cycle.
- Assert `reset` during EXEC and during RESP → no response emitted; all outputs at reset values the next cycle; the next grant goes to req0 when both are valid.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and opcode constants for the ALU arbiter slice.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational RV32-style integer ALU selected by funct7/funct3.
module alu
  import alu_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] source1,
  input  logic [XLEN-1:0] source2,
  output logic [XLEN-1:0] result
);

  localparam int SW = $clog2(XLEN);

  logic          alt;
  logic [SW-1:0] shamt;
  logic          lt_s;
  logic          lt_u;

  assign alt   = (funct7 == F7_ALT);
  assign shamt = source2[SW-1:0];
  assign lt_s  = $signed(source1) < $signed(source2);
  assign lt_u  = source1 < source2;

  always_comb begin
    result = '0;
    case (funct3)
      F3_ADD:  result = alt ? source1 - source2
                            : source1 + source2;
      F3_SLL:  result = source1 << shamt;
      F3_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      F3_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      F3_XOR:  result = source1 ^ source2;
      F3_SR:   result = alt
        ? XLEN'($signed(source1) >>> shamt)
        : source1 >> shamt;
      F3_OR:   result = source1 | source2;
      F3_AND:  result = source1 & source2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters,
// with a registered, ID-tagged response channel.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [13:0]       req_funct7,
  input  logic [5:0]        req_funct3,
  input  logic [2*XLEN-1:0] req_src1,
  input  logic [2*XLEN-1:0] req_src2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [XLEN-1:0]   rsp_result,
  output logic              busy
);

  state_t          state_q;
  state_t          state_d;
  logic            prio_q;
  logic            id_q;
  logic [6:0]      f7_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] s1_q;
  logic [XLEN-1:0] s2_q;
  logic [XLEN-1:0] alu_out;
  logic            grant;
  logic            take;

  assign grant = (&req_valid) ? prio_q
                              : req_valid[1];

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    case (state_q)
      ST_IDLE: begin
        // never accept while reset is discarding the handshake
        if (|req_valid && !reset) begin
          req_ready[grant] = 1'b1;
          state_d          = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign take      = |req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      id_q       <= 1'b0;
      f7_q       <= '0;
      f3_q       <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        id_q <= grant;
        f7_q <= grant ? req_funct7[13:7]
                      : req_funct7[6:0];
        f3_q <= grant ? req_funct3[5:3]
                      : req_funct3[2:0];
        s1_q <= grant ? req_src1[XLEN +: XLEN]
                      : req_src1[0 +: XLEN];
        s2_q <= grant ? req_src2[XLEN +: XLEN]
                      : req_src2[0 +: XLEN];
      end
      if (state_q == ST_EXEC) begin
        rsp_result <= alu_out;
        rsp_id     <= id_q;
      end
      // the loser of the last contest gets first pick next time
      if (state_q == ST_RESP && rsp_ready)
        prio_q <= ~id_q;
    end
  end

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .funct7 (f7_q),
    .funct3 (f3_q),
    .source1(s1_q),
    .source2(s2_q),
    .result (alu_out)
  );

endmodule
